// File: rtl/param_register_file.sv
// Parametrised 2-read/1-write register file with a post-reset sequential clear engine.
// Reads are combinational with optional same-cycle write forwarding; writes land on the rising edge.
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              writeSig,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] sourceReg,
    output logic [DATA_W-1:0] secondaryReg,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] clrCnt;
    logic [ADDR_W-1:0] nextClrCnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              writeAccept;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else begin
            state  <= nextState;
            clrCnt <= nextClrCnt;
        end
    end

    assign ready       = (state == READY);
    assign writeAccept = (state == READY) && writeSig && !Rst && !(ZERO_REG && (rd == '0));

    // The clear engine and the normal write path share the single memory write port.
    always_comb begin
        nextState  = state;
        nextClrCnt = clrCnt;
        memWe      = 1'b0;
        memAddr    = rd;
        memData    = writeData;
        case (state)
            CLEAR: begin
                memWe      = !Rst;
                memAddr    = clrCnt;
                memData    = '0;
                nextClrCnt = clrCnt + ADDR_W'(1);
                if (clrCnt == ADDR_W'(DEPTH - 1)) begin
                    nextState = READY;
                end
            end
            READY: begin
                memWe = writeAccept;
            end
            default: begin
                nextState = CLEAR;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    // Priority: not ready, then hardwired zero, then forwarding, then stored value.
    always_comb begin
        sourceReg = mem[rs];
        if (!ready) begin
            sourceReg = '0;
        end else if (ZERO_REG && (rs == '0)) begin
            sourceReg = '0;
        end else if (BYPASS && writeAccept && (rs == rd)) begin
            sourceReg = writeData;
        end
    end

    always_comb begin
        secondaryReg = mem[rt];
        if (!ready) begin
            secondaryReg = '0;
        end else if (ZERO_REG && (rt == '0)) begin
            secondaryReg = '0;
        end else if (BYPASS && writeAccept && (rt == rd)) begin
            secondaryReg = writeData;
        end
    end

endmodule
